multicycle_controller: RTL and testbench

Control FSM for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal). It sequences the shared PC/ALU/memory datapath one instruction at a time, from the opcode in the instruction register. It stalls on a memory-ready handshake, flags illegal opcodes, and counts retired instructions. It replaces single-cycle main decoding in the multicycle datapath top level.

---
 rtl/multicycle_controller.sv | 168 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences the shared PC/ALU/memory
// datapath per opcode, stalls on MemReady, traps illegal opcodes, counts retires.
module multicycle_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ImmSrc,
    output logic             RegWrite,
    output logic             Illegal,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrRet
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRead = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecR   = 4'd6,
        StAluWb   = 4'd7,
        StExecI   = 4'd8,
        StJal     = 4'd9,
        StBeq     = 4'd10,
        StTrap    = 4'd11
    } state_e;

    localparam logic [6:0] OpLw   = 7'b0000011;
    localparam logic [6:0] OpSw   = 7'b0100011;
    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpI    = 7'b0010011;
    localparam logic [6:0] OpJal  = 7'b1101111;
    localparam logic [6:0] OpBeq  = 7'b1100011;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q;
    logic             pcupdate, branch, retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        pcupdate  = 1'b0;
        branch    = 1'b0;
        retire    = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        RegWrite  = 1'b0;
        unique case (state_q)
            StFetch: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (MemReady) begin
                    IRWrite  = 1'b1;
                    pcupdate = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                if (op == OpLw || op == OpSw) state_d = StMemAdr;
                else if (op == OpR)           state_d = StExecR;
                else if (op == OpI)           state_d = StExecI;
                else if (op == OpJal)         state_d = StJal;
                else if (op == OpBeq)         state_d = StBeq;
                else                          state_d = StTrap;
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OpLw) ? StMemRead : StMemWr;
            end
            StMemRead: begin
                AdrSrc = 1'b1;
                if (MemReady) state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StMemWr: begin
                // Strobe stays high across the whole stall, not just the ready cycle.
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StExecR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = StAluWb;
            end
            StExecI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = StAluWb;
            end
            StAluWb: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            StJal: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                pcupdate = 1'b1;
                state_d  = StAluWb;
            end
            StBeq: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
                retire  = 1'b1;
                state_d = StFetch;
            end
            StTrap: state_d = StTrap;
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        case (op)
            OpLw, OpI: ImmSrc = 2'b00;
            OpSw:      ImmSrc = 2'b01;
            OpBeq:     ImmSrc = 2'b10;
            OpJal:     ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

    assign PCWrite  = pcupdate | (branch & Zero);
    assign Illegal  = (state_q == StTrap);
    assign State    = state_q;
    assign InstrRet = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed and random instruction streams checked
// against an instruction-level model (state path per opcode plus per-state control table).
module tb_multicycle_controller;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [6:0]       op = 7'b0000011;
    logic             Zero = 1'b0;
    logic             MemReady = 1'b1;
    logic             PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrRet;

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .Zero      (Zero),
        .MemReady  (MemReady),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .ImmSrc    (ImmSrc),
        .RegWrite  (RegWrite),
        .Illegal   (Illegal),
        .State     (State),
        .InstrRet  (InstrRet)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: the whole instruction is a list of states; stalls repeat a state.
    int         path[$];
    int         pi;
    int         m_cnt;
    logic [6:0] m_op;

    function automatic void load_path(input logic [6:0] o);
        case (o)
            7'b0000011: path = '{0, 1, 2, 3, 4};
            7'b0100011: path = '{0, 1, 2, 5};
            7'b0110011: path = '{0, 1, 6, 7};
            7'b0010011: path = '{0, 1, 8, 7};
            7'b1101111: path = '{0, 1, 9, 7};
            7'b1100011: path = '{0, 1, 10};
            default:    path = '{0, 1, 11};
        endcase
    endfunction

    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
    //  RegWrite, Illegal}
    function automatic logic [15:0] exp_ctrl(input int s, input logic [6:0] o, input bit z,
                                             input bit mr);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb, aop, imm;
        {pcw, adr, mw, irw, rw, ill} = '0;
        {rs, sa, sb, aop} = '0;
        imm = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 :
              (o == 7'b1101111) ? 2'b11 : 2'b00;
        case (s)
            0:  begin sb = 2; rs = 2; irw = mr; pcw = mr; end
            1:  begin sa = 1; sb = 1; end
            2:  begin sa = 2; sb = 1; end
            3:  adr = 1;
            4:  begin rs = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2; aop = 2; end
            7:  rw = 1;
            8:  begin sa = 2; sb = 1; aop = 2; end
            9:  begin sa = 1; sb = 2; pcw = 1; end
            10: begin sa = 2; aop = 1; pcw = z; end
            11: ill = 1;
            default: ;
        endcase
        return {pcw, adr, mw, irw, rs, sa, sb, aop, imm, rw, ill};
    endfunction

    task automatic set_op(input logic [6:0] o);
        op = o;
        m_op = o;
        load_path(o);
    endtask

    task automatic step(input bit mr, input bit z, input bit rst);
        logic [15:0] got, want;
        int s;
        @(negedge clk);
        MemReady = mr;
        Zero = z;
        reset = rst;
        #1;
        s = path[pi];
        want = exp_ctrl(s, m_op, z, mr);
        got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
               ImmSrc, RegWrite, Illegal};
        checks++;
        assert (State === 4'(s)) else begin
            errors++;
            $error("FAIL state: got %0d want %0d", State, s);
        end
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL ctrl(state %0d op %b): got %h want %h", s, m_op, got, want);
        end
        checks++;
        assert (InstrRet === CNT_W'(m_cnt)) else begin
            errors++;
            $error("FAIL instret: got %0d want %0d", InstrRet, m_cnt);
        end
        @(posedge clk);
        if (rst) begin
            pi = 0;
            m_cnt = 0;
            load_path(m_op);
        end else if (s == 11) begin
            pi = pi;
        end else if (!((s == 0 || s == 3 || s == 5) && !mr)) begin
            if (pi == path.size() - 1) begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                pi = 0;
            end else begin
                pi++;
            end
        end
    endtask

    logic [6:0] legal_ops [6];

    initial begin
        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                      7'b1100011};
        m_cnt = 0;
        pi = 0;
        set_op(7'b0000011);
        reset = 1'b1;
        @(posedge clk);

        // lw with no stalls, first cycle doubles as reset-state check
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        // sw stalled three cycles in the write state
        set_op(7'b0100011);
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        step(1, 0, 0);
        // beq taken then not taken
        set_op(7'b1100011);
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        // jal
        set_op(7'b1101111);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        // fetch stall then R-type and I-type
        set_op(7'b0110011);
        step(0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        set_op(7'b0010011);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        // illegal opcode traps and holds
        set_op(7'b1111111);
        for (int i = 0; i < 12; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        step(1, 0, 1);
        // reset taken while in EXECR
        set_op(7'b0110011);
        for (int i = 0; i < 2; i++) step(1, 0, 0);
        step(1, 0, 1);
        step(0, 0, 0);

        // random legal stream with random memory stalls; counter wraps
        for (int i = 0; i < 400; i++) begin
            if (pi == 0) set_op(legal_ops[$urandom_range(0, 5)]);
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
